// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank.
// One shared BCD decoder; per-slot blank/drive timing, per-frame digit snapshot, per-digit blink.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 6,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_flat,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blink_tick,
  output logic [3:0]              digit_out,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic [SW-1:0]           slot_idx,
  output logic                    frame_start
);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_DRIVE = CW'(BLANK_CYCLES);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);

  state_t                  state, nxt_state;
  logic [CW-1:0]           cnt, nxt_cnt;
  logic [SW-1:0]           nxt_slot;
  logic [4*NUM_DIGITS-1:0] snap, nxt_snap;
  logic                    nxt_fs;
  logic                    phase, nxt_phase;
  logic [NUM_DIGITS-1:0]   nxt_anode_n;
  logic [3:0]              nxt_digit;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_slot  = slot_idx;
    nxt_snap  = snap;
    nxt_fs    = 1'b0;
    nxt_phase = phase ^ blink_tick;
    if (!enable) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
      nxt_slot  = '0;
      nxt_snap  = '0;
    end else begin
      case (state)
        IDLE: begin
          nxt_state = BLANK;
          nxt_cnt   = '0;
          nxt_slot  = '0;
          nxt_snap  = digits_flat;
          nxt_fs    = 1'b1;
        end
        default: begin
          if (cnt == CNT_LAST) begin
            nxt_cnt = '0;
            if (slot_idx == SLOT_LAST) begin
              nxt_slot = '0;
              nxt_snap = digits_flat;
              nxt_fs   = 1'b1;
            end else begin
              nxt_slot = slot_idx + 1'b1;
            end
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
          nxt_state = (nxt_cnt >= CNT_DRIVE) ? DRIVE : BLANK;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state view so they line up with the state they describe.
  always_comb begin
    nxt_anode_n = '1;
    nxt_digit   = 4'hF;
    if (nxt_state == DRIVE && !(blink_mask[nxt_slot] && nxt_phase)) begin
      nxt_anode_n[nxt_slot] = 1'b0;
      nxt_digit             = nxt_snap[4*nxt_slot +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      slot_idx    <= '0;
      snap        <= '0;
      frame_start <= 1'b0;
      phase       <= 1'b0;
      anode_n     <= '1;
      digit_out   <= 4'hF;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      slot_idx    <= nxt_slot;
      snap        <= nxt_snap;
      frame_start <= nxt_fs;
      phase       <= nxt_phase;
      anode_n     <= nxt_anode_n;
      digit_out   <= nxt_digit;
    end
  end

endmodule
